// File: rtl/coffee_dispense_ctrl.sv
// coffee_dispense_ctrl: queues paid vends and runs each one through cup drop, heater wait, pour and done.
// Optional cup-sensor supervision (timeout into a sticky FAULT) is built when COFFEE_CUP_SENSOR_EN is defined.
module coffee_dispense_ctrl #(
  parameter int MAX_PENDING = 3,
  parameter int PEND_W      = 2,
  parameter int CUP_CYCLES  = 4,
  parameter int POUR_CYCLES = 8,
  parameter int CUP_TIMEOUT = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              vend_req,
  input  logic              heater_ready,
  input  logic              cup_present,
  output logic              cup_drop,
  output logic              pour_valve,
  output logic              busy,
  output logic              done,
  output logic              overflow,
  output logic [PEND_W-1:0] pending,
  output logic              fault
);

`ifdef COFFEE_CUP_SENSOR_EN
  localparam int CUP_SPAN = CUP_CYCLES + CUP_TIMEOUT;
`else
  localparam int CUP_SPAN = CUP_CYCLES;
`endif
  localparam int TMR_MAX = (CUP_SPAN > POUR_CYCLES) ? CUP_SPAN : POUR_CYCLES;
  localparam int TMR_W   = $clog2(TMR_MAX + 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_CUP,
    S_HEAT,
    S_POUR,
    S_DONE
`ifdef COFFEE_CUP_SENSOR_EN
    , S_FAULT
`endif
  } state_t;

  state_t            state_q, state_d;
  logic [TMR_W-1:0]  timer_q, timer_d;
  logic [PEND_W-1:0] pending_q, pending_d;
  logic              cup_drop_q, cup_drop_d;
  logic              pour_valve_q, pour_valve_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              overflow_q, overflow_d;
  logic              vend_finish;
  logic              vend_accept;

  // A vend leaving DONE frees a slot in the same edge, so a coincident request is always taken.
  assign vend_finish = (state_q == S_DONE);
  assign vend_accept = vend_req && ((pending_q < PEND_W'(MAX_PENDING)) || vend_finish);

  always_comb begin
    state_d   = state_q;
    timer_d   = timer_q;
    pending_d = pending_q;

    if (vend_accept && !vend_finish) begin
      pending_d = pending_q + PEND_W'(1);
    end else if (!vend_accept && vend_finish) begin
      pending_d = pending_q - PEND_W'(1);
    end

    case (state_q)
      S_IDLE: begin
        timer_d = '0;
        if (pending_d != '0) begin
          state_d = S_CUP;
        end
      end
      S_CUP: begin
`ifdef COFFEE_CUP_SENSOR_EN
        if ((timer_q >= TMR_W'(CUP_CYCLES - 1)) && cup_present) begin
          state_d = S_HEAT;
          timer_d = '0;
        end else if (timer_q == TMR_W'(CUP_SPAN - 1)) begin
          state_d = S_FAULT;
          timer_d = '0;
        end else begin
          timer_d = timer_q + TMR_W'(1);
        end
`else
        if (timer_q == TMR_W'(CUP_CYCLES - 1)) begin
          state_d = S_HEAT;
          timer_d = '0;
        end else begin
          timer_d = timer_q + TMR_W'(1);
        end
`endif
      end
      S_HEAT: begin
        timer_d = '0;
        if (heater_ready) begin
          state_d = S_POUR;
        end
      end
      S_POUR: begin
        // The valve runs its full count even if the heater drops out mid-pour.
        if (timer_q == TMR_W'(POUR_CYCLES - 1)) begin
          state_d = S_DONE;
          timer_d = '0;
        end else begin
          timer_d = timer_q + TMR_W'(1);
        end
      end
      S_DONE: begin
        timer_d = '0;
        state_d = (pending_d != '0) ? S_CUP : S_IDLE;
      end
`ifdef COFFEE_CUP_SENSOR_EN
      S_FAULT: begin
        timer_d = '0;
      end
`endif
      default: begin
        state_d = S_IDLE;
        timer_d = '0;
      end
    endcase

    cup_drop_d   = (state_d == S_CUP) && (state_q != S_CUP);
    pour_valve_d = (state_d == S_POUR);
    busy_d       = (state_d != S_IDLE);
    done_d       = (state_d == S_DONE);
    overflow_d   = vend_req && !vend_accept;
  end

`ifdef COFFEE_CUP_SENSOR_EN
  logic fault_q, fault_d;

  assign fault_d = (state_d == S_FAULT);

  always_ff @(posedge clk) begin
    if (reset) begin
      fault_q <= 1'b0;
    end else begin
      fault_q <= fault_d;
    end
  end

  assign fault = fault_q;
`else
  logic cup_present_unused;

  assign cup_present_unused = cup_present;
  assign fault              = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= S_IDLE;
      timer_q      <= '0;
      pending_q    <= '0;
      cup_drop_q   <= 1'b0;
      pour_valve_q <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      overflow_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      timer_q      <= timer_d;
      pending_q    <= pending_d;
      cup_drop_q   <= cup_drop_d;
      pour_valve_q <= pour_valve_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      overflow_q   <= overflow_d;
    end
  end

  assign cup_drop   = cup_drop_q;
  assign pour_valve = pour_valve_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign overflow   = overflow_q;
  assign pending    = pending_q;

endmodule

// File: tb/tb_coffee_dispense_ctrl.sv
// Self-checking bench for coffee_dispense_ctrl (default build): vector table for single vends plus
// hand-written burst, coincident-done and reset-abort sequences; done pulses checked by a scoreboard.
module tb_coffee_dispense_ctrl;
  localparam int PEND_W    = 2;
  localparam int VEND_SPAN = 14;  // vend_req cycle to DONE cycle with heater ready

  logic              clk = 1'b0;
  logic              reset;
  logic              vend_req;
  logic              heater_ready;
  logic              cup_present;
  logic              cup_drop;
  logic              pour_valve;
  logic              busy;
  logic              done;
  logic              overflow;
  logic [PEND_W-1:0] pending;
  logic              fault;

  int checks     = 0;
  int failures   = 0;
  int cyc        = 0;
  int done_seen  = 0;
  int last_sched = 0;
  int exp_done_q[$];

  coffee_dispense_ctrl #(
    .MAX_PENDING(3),
    .PEND_W     (PEND_W),
    .CUP_CYCLES (4),
    .POUR_CYCLES(8),
    .CUP_TIMEOUT(16)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .vend_req    (vend_req),
    .heater_ready(heater_ready),
    .cup_present (cup_present),
    .cup_drop    (cup_drop),
    .pour_valve  (pour_valve),
    .busy        (busy),
    .done        (done),
    .overflow    (overflow),
    .pending     (pending),
    .fault       (fault)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Each accepted vend finishes one VEND_SPAN after the later of its request and the vend ahead of it.
  task automatic sched_vend(input int req_cyc, input int extra);
    int e;
    e = ((last_sched > req_cyc) ? last_sched : req_cyc) + VEND_SPAN + extra;
    last_sched = e;
    exp_done_q.push_back(e);
  endtask

  always @(posedge clk) begin : done_monitor
    int e;
    #1;
    if (done === 1'b1) begin
      done_seen++;
      if (exp_done_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_done: got done at cycle %0d, expected none", cyc);
      end else begin
        e = exp_done_q.pop_front();
        chk("done_cycle", cyc, e);
        $display("vend done at cycle %0d (expected %0d)", cyc, e);
      end
    end
  end

  typedef struct {
    int heat_wait;
    int exp_cup_rel;
    int exp_pour_rel;
    int exp_pour_len;
    int exp_done_rel;
  } vec_t;

  vec_t vecs[3];

  initial begin
    int k;
    int d0;
    int cup_rel, cup_cnt, pour_rel, pour_cnt, done_rel, ovf_cnt, gap_cnt, flt_cnt, busy_cnt;

    vecs[0] = '{0, 1, 6, 8, 14};
    vecs[1] = '{3, 1, 9, 8, 17};
    vecs[2] = '{20, 1, 26, 8, 34};

    reset        = 1'b1;
    vend_req     = 1'b0;
    heater_ready = 1'b0;
    cup_present  = 1'b0;
    repeat (3) tick();
    chk("reset_outputs", {cup_drop, pour_valve, busy, done, overflow, fault, pending}, '0);
    reset = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("idle_outputs", {cup_drop, pour_valve, busy, done, overflow, fault, pending}, '0);
    end

    // Single vends with varying heater warm-up time.
    for (int v = 0; v < 3; v++) begin
      k = cyc;
      vend_req     = 1'b1;
      heater_ready = 1'b0;
      sched_vend(k, vecs[v].heat_wait);
      cup_rel = -1; cup_cnt = 0; pour_rel = -1; pour_cnt = 0; done_rel = -1;
      for (int r = 1; r <= 40; r++) begin
        tick();
        vend_req     = 1'b0;
        heater_ready = (r >= 5 + vecs[v].heat_wait);
        if (r == 1) chk("pending_one", pending, 1);
        if (cup_drop === 1'b1) begin
          cup_cnt++;
          if (cup_rel < 0) cup_rel = r;
        end
        if (pour_valve === 1'b1) begin
          pour_cnt++;
          if (pour_rel < 0) pour_rel = r;
        end
        if (done === 1'b1 && done_rel < 0) done_rel = r;
        if (r == vecs[v].exp_done_rel + 1) begin
          chk("pending_after", pending, 0);
          chk("busy_after", busy, 0);
        end
      end
      chk("cup_rel", cup_rel, vecs[v].exp_cup_rel);
      chk("cup_count", cup_cnt, 1);
      chk("pour_rel", pour_rel, vecs[v].exp_pour_rel);
      chk("pour_len", pour_cnt, vecs[v].exp_pour_len);
      chk("done_rel", done_rel, vecs[v].exp_done_rel);
      $display("vector %0d heat_wait=%0d cup@%0d pour@%0d len=%0d done@%0d", v, vecs[v].heat_wait,
               cup_rel, pour_rel, pour_cnt, done_rel);
    end
    heater_ready = 1'b1;
    tick();

    // Burst of four requests: the fourth overflows, three vends run back to back.
    k = cyc; d0 = done_seen; ovf_cnt = 0; gap_cnt = 0; flt_cnt = 0;
    for (int i = 0; i < 4; i++) begin
      vend_req = 1'b1;
      if (i < 3) sched_vend(cyc, 0);
      tick();
      if (overflow === 1'b1) ovf_cnt++;
      if (i == 2) chk("burst_pending_full", pending, 3);
      if (i == 3) chk("burst_overflow_pulse", overflow, 1);
    end
    vend_req = 1'b0;
    for (int r = 5; r <= 43; r++) begin
      tick();
      if (overflow === 1'b1) ovf_cnt++;
      if (fault !== 1'b0) flt_cnt++;
      if (r <= 42 && busy !== 1'b1) gap_cnt++;
    end
    chk("burst_overflow_count", ovf_cnt, 1);
    chk("burst_idle_gaps", gap_cnt, 0);
    chk("burst_fault_low", flt_cnt, 0);
    chk("burst_done_count", done_seen - d0, 3);
    chk("burst_pending_end", pending, 0);
    chk("burst_busy_end", busy, 0);
    $display("burst: overflows=%0d dones=%0d", ovf_cnt, done_seen - d0);

    // Request landing on the DONE cycle while full is accepted with no net change.
    k = cyc; d0 = done_seen; ovf_cnt = 0;
    for (int i = 0; i < 3; i++) begin
      vend_req = 1'b1;
      sched_vend(cyc, 0);
      tick();
    end
    vend_req = 1'b0;
    while (cyc < k + VEND_SPAN) tick();
    chk("coinc_done_now", done, 1);
    chk("coinc_pending_before", pending, 3);
    vend_req = 1'b1;
    sched_vend(cyc, 0);
    tick();
    vend_req = 1'b0;
    chk("coinc_pending_after", pending, 3);
    chk("coinc_no_overflow", overflow, 0);
    for (int r = k + 16; r <= k + 57; r++) begin
      tick();
      if (overflow === 1'b1) ovf_cnt++;
    end
    chk("coinc_overflow_count", ovf_cnt, 0);
    chk("coinc_done_count", done_seen - d0, 4);
    chk("coinc_pending_end", pending, 0);
    $display("coincident: dones=%0d", done_seen - d0);

    // Reset mid-pour aborts the vend and discards the queued one.
    k = cyc;
    for (int i = 0; i < 2; i++) begin
      vend_req = 1'b1;
      sched_vend(cyc, 0);
      tick();
    end
    vend_req = 1'b0;
    while (cyc < k + 8) tick();
    chk("pre_reset_pouring", pour_valve, 1);
    chk("pre_reset_pending", pending, 2);
    reset = 1'b1;
    exp_done_q.delete();
    last_sched = 0;
    tick();
    reset = 1'b0;
    chk("reset_pour_off", pour_valve, 0);
    chk("reset_pending_zero", pending, 0);
    chk("reset_busy_low", busy, 0);
    busy_cnt = 0;
    for (int r = 0; r < 20; r++) begin
      tick();
      if (busy !== 1'b0) busy_cnt++;
    end
    chk("post_reset_stays_idle", busy_cnt, 0);
    $display("reset abort: pending=%0d busy_cycles=%0d", pending, busy_cnt);

    chk("scoreboard_drained", exp_done_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
